// File: rtl/snn_xor_infer_ctrl_pkg.sv
// Shared controller definitions: FSM state encoding and default timing constants
// used by the XOR inference controller and later multi-core schedulers.
package snn_ctrl_pkg;

  localparam logic [2:0] STATE_IDLE   = 3'd0;
  localparam logic [2:0] STATE_CLEAR  = 3'd1;
  localparam logic [2:0] STATE_RUN    = 3'd2;
  localparam logic [2:0] STATE_DRAIN  = 3'd3;
  localparam logic [2:0] STATE_REPORT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = STATE_IDLE,
    ST_CLEAR  = STATE_CLEAR,
    ST_RUN    = STATE_RUN,
    ST_DRAIN  = STATE_DRAIN,
    ST_REPORT = STATE_REPORT
  } ctrl_state_t;

  localparam int DEFAULT_SETTLE_CYCLES = 4;
  localparam int DEFAULT_WINDOW_CYCLES = 64;
  localparam int DEFAULT_SPIKE_PERIOD  = 2;
  localparam int DEFAULT_DRAIN_CYCLES  = 4;
  localparam int DEFAULT_OUT_THRESH    = 2;
  localparam int DEFAULT_CNT_WIDTH     = 8;

  // Sizes the shared duration counter to the longest phase.
  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/snn_xor_infer_ctrl_if.sv
// Host-side request/result handshake bundle for the XOR inference controller.
interface snn_xor_infer_ctrl_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_a;
  logic                 req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_xor;
  logic [CNT_WIDTH-1:0] res_spike_count;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_xor, res_spike_count
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_xor, res_spike_count
  );
endinterface

// File: rtl/snn_xor_infer_ctrl_enc.sv
// Rate encoder: emits a registered spike on phase 0 of a free-running period
// while enabled and the input level is high.
module snn_spike_rate_encoder #(
  parameter int SPIKE_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic level,
  output logic spike
);

  localparam int PW = (SPIKE_PERIOD > 1) ? $clog2(SPIKE_PERIOD) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SPIKE_PERIOD - 1);

  logic [PW-1:0] phase_reg;
  logic          spike_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
      spike_reg <= 1'b0;
    end else if (clr) begin
      phase_reg <= '0;
      spike_reg <= 1'b0;
    end else if (en) begin
      spike_reg <= level & (phase_reg == '0);
      phase_reg <= (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
    end else begin
      spike_reg <= 1'b0;
    end
  end

  assign spike = spike_reg;

endmodule

// File: rtl/snn_xor_infer_ctrl.sv
// Sequences one XOR inference per request: clears the SNN core, drives
// rate-coded inputs for a window, drains, and reports a thresholded spike count.
module snn_xor_infer_ctrl
  import snn_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int SPIKE_PERIOD  = DEFAULT_SPIKE_PERIOD,
  parameter int DRAIN_CYCLES  = DEFAULT_DRAIN_CYCLES,
  parameter int OUT_THRESH    = DEFAULT_OUT_THRESH,
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  snn_xor_infer_ctrl_if.slave  bus,
  output logic                 core_rst_n,
  output logic                 core_spike_in_0,
  output logic                 core_spike_in_1,
  output logic                 core_switch_0,
  output logic                 core_switch_1,
  input  logic                 core_spike_out,
  output logic                 busy
);

  localparam int DUR_MAX = max3(SETTLE_CYCLES, WINDOW_CYCLES, DRAIN_CYCLES);
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam logic [DUR_W-1:0] SETTLE_LOAD = DUR_W'(SETTLE_CYCLES - 1);
  localparam logic [DUR_W-1:0] WINDOW_LOAD = DUR_W'(WINDOW_CYCLES - 1);
  localparam logic [DUR_W-1:0] DRAIN_LOAD  = DUR_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  ctrl_state_t          state_reg;
  logic [DUR_W-1:0]     dur_reg;
  logic                 a_reg, b_reg;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 req_ready_reg, res_valid_reg, res_xor_reg;
  logic [CNT_WIDTH-1:0] res_count_reg;
  logic                 core_rst_n_reg, switch_0_reg, switch_1_reg, busy_reg;
  logic                 counting, accept, enc_clr, enc_en;
  logic [1:0]           enc_level, enc_spike;

  function automatic logic thresh_met(input logic [CNT_WIDTH-1:0] c);
    return (int'(c) >= OUT_THRESH);
  endfunction

  assign counting = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign accept   = (state_reg == ST_IDLE) && bus.req_valid && req_ready_reg;

  // Saturating count; spikes outside the RUN/DRAIN window never reach it.
  always_comb begin
    cnt_next = cnt_reg;
    if (counting && core_spike_out && !(&cnt_reg))
      cnt_next = cnt_reg + 1'b1;
  end

  // Encoder outputs are registered, so enable reflects the state of the next cycle.
  assign enc_clr = accept;
  assign enc_en  = ((state_reg == ST_CLEAR) && (dur_reg == '0)) ||
                   ((state_reg == ST_RUN) && (dur_reg != '0));
  assign enc_level = {b_reg, a_reg};

  for (genvar gi = 0; gi < 2; gi++) begin : g_enc
    snn_spike_rate_encoder #(
      .SPIKE_PERIOD(SPIKE_PERIOD)
    ) u_enc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (enc_clr),
      .en    (enc_en),
      .level (enc_level[gi]),
      .spike (enc_spike[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      dur_reg        <= '0;
      a_reg          <= 1'b0;
      b_reg          <= 1'b0;
      cnt_reg        <= '0;
      req_ready_reg  <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_xor_reg    <= 1'b0;
      res_count_reg  <= '0;
      core_rst_n_reg <= 1'b0;
      switch_0_reg   <= 1'b0;
      switch_1_reg   <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          req_ready_reg  <= 1'b1;
          core_rst_n_reg <= 1'b1;
          if (accept) begin
            a_reg          <= bus.req_a;
            b_reg          <= bus.req_b;
            cnt_reg        <= '0;
            dur_reg        <= SETTLE_LOAD;
            req_ready_reg  <= 1'b0;
            core_rst_n_reg <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (dur_reg == '0) begin
            core_rst_n_reg <= 1'b1;
            switch_0_reg   <= a_reg;
            switch_1_reg   <= b_reg;
            dur_reg        <= WINDOW_LOAD;
            state_reg      <= ST_RUN;
          end else begin
            dur_reg <= dur_reg - 1'b1;
          end
        end
        ST_RUN, ST_DRAIN: begin
          cnt_reg <= cnt_next;
          if (dur_reg != '0) begin
            dur_reg <= dur_reg - 1'b1;
          end else if ((state_reg == ST_RUN) && (DRAIN_CYCLES > 0)) begin
            dur_reg   <= DRAIN_LOAD;
            state_reg <= ST_DRAIN;
          end else begin
            // Result captures this cycle's spike too, so it uses cnt_next.
            res_valid_reg <= 1'b1;
            res_count_reg <= cnt_next;
            res_xor_reg   <= thresh_met(cnt_next);
            switch_0_reg  <= 1'b0;
            switch_1_reg  <= 1'b0;
            state_reg     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready       = req_ready_reg;
  assign bus.res_valid       = res_valid_reg;
  assign bus.res_xor         = res_xor_reg;
  assign bus.res_spike_count = res_count_reg;
  assign core_rst_n          = core_rst_n_reg;
  assign core_spike_in_0     = enc_spike[0];
  assign core_spike_in_1     = enc_spike[1];
  assign core_switch_0       = switch_0_reg;
  assign core_switch_1       = switch_1_reg;
  assign busy                = busy_reg;

endmodule

// File: tb/tb_snn_xor_infer_ctrl.sv
// Table-driven and randomized bench for the XOR inference controller, with a
// window-based spike-count reference model and a small saturating instance.
module tb_snn_xor_infer_ctrl;
  import snn_ctrl_pkg::*;

  localparam int S   = 4;
  localparam int W   = 64;
  localparam int P   = 2;
  localparam int D   = 4;
  localparam int TH  = 2;
  localparam int CW  = 8;
  localparam int LAT = S + W + D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_xor_infer_ctrl_if #(.CNT_WIDTH(CW)) bus ();
  logic core_rst_n, sp0, sp1, sw0, sw1, core_spike_out, busy;

  snn_xor_infer_ctrl #(
    .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .SPIKE_PERIOD(P),
    .DRAIN_CYCLES(D), .OUT_THRESH(TH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .core_rst_n(core_rst_n), .core_spike_in_0(sp0), .core_spike_in_1(sp1),
    .core_switch_0(sw0), .core_switch_1(sw1),
    .core_spike_out(core_spike_out), .busy(busy)
  );

  // Saturation instance: short window, spike every cycle, no drain, 4-bit counter.
  snn_xor_infer_ctrl_if #(.CNT_WIDTH(4)) bus_s ();
  logic s_core_rst_n, s_sp0, s_sp1, s_sw0, s_sw1, s_spike_out, s_busy;

  snn_xor_infer_ctrl #(
    .SETTLE_CYCLES(1), .WINDOW_CYCLES(20), .SPIKE_PERIOD(1),
    .DRAIN_CYCLES(0), .OUT_THRESH(2), .CNT_WIDTH(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s),
    .core_rst_n(s_core_rst_n), .core_spike_in_0(s_sp0), .core_spike_in_1(s_sp1),
    .core_switch_0(s_sw0), .core_switch_1(s_sw1),
    .core_spike_out(s_spike_out), .busy(s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic a;
    logic b;
    int   mode;
    int   bp;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[7];

  // Stub core spike pattern for the cycle sampled at edge accept+k+1.
  function automatic logic spike_for(input int mode, input int k);
    case (mode)
      0: return ($urandom_range(0, 3) == 0);
      1: return (k == S + 5) || (k == S + 20) || (k == S + 40);
      3: return 1'b1;
      5: return (k == S - 1) || (k == LAT - 1) || (k == LAT);
      6: return (k == S - 1) || (k == S) || (k == LAT - 1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_ready(input string name);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!bus.req_ready && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    check(name, bus.req_ready, 1);
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int   model, expc, pulses0, pulses1, sw0hi, sw1hi, rstlo;
    logic early_valid, bp_bad;
    logic [CW-1:0] cnt_seen;
    logic xor_seen;
    model = 0; pulses0 = 0; pulses1 = 0; sw0hi = 0; sw1hi = 0; rstlo = 0;
    early_valid = 1'b0; bp_bad = 1'b0;

    wait_ready("req_ready_idle");
    bus.req_valid = 1'b1;
    bus.req_a = v.a;
    bus.req_b = v.b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a = ~v.a;
    bus.req_b = ~v.b;
    for (int k = 0; k <= LAT; k++) begin
      core_spike_out = spike_for(v.mode, k);
      if (core_spike_out && k >= S && k <= LAT - 1) model++;
      @(negedge clk);
      pulses0 += int'(sp0);
      pulses1 += int'(sp1);
      sw0hi   += int'(sw0);
      sw1hi   += int'(sw1);
      rstlo   += int'(!core_rst_n);
      if (k < LAT) begin
        early_valid |= bus.res_valid;
        @(posedge clk);
        #1;
      end
    end
    check("res_valid_at_latency", bus.res_valid, 1);
    check("res_valid_early", early_valid, 0);
    check("spike_in_0_pulses", pulses0, v.a ? (W + P - 1) / P : 0);
    check("spike_in_1_pulses", pulses1, v.b ? (W + P - 1) / P : 0);
    check("switch_0_cycles", sw0hi, v.a ? W + D : 0);
    check("switch_1_cycles", sw1hi, v.b ? W + D : 0);
    check("core_rst_low_cycles", rstlo, S);

    expc = (v.exp_cnt >= 0) ? v.exp_cnt : model;
    check("res_spike_count", bus.res_spike_count, (expc > 255) ? 255 : expc);
    check("res_xor", bus.res_xor, (expc >= TH) ? 1 : 0);
    check("busy_report", busy, 1);
    cnt_seen = bus.res_spike_count;
    xor_seen = bus.res_xor;

    bus.res_ready = 1'b0;
    bus.req_valid = (v.bp > 0);
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clk);
      #1;
      core_spike_out = spike_for(v.mode, LAT + 1 + i);
      @(negedge clk);
      if (bus.res_spike_count != cnt_seen || bus.res_xor != xor_seen ||
          !bus.res_valid || bus.req_ready)
        bp_bad = 1'b1;
    end
    check("backpressure_stable", bp_bad, 0);

    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
    core_spike_out = 1'b0;
    @(negedge clk);
    check("res_valid_after_hs", bus.res_valid, 0);
    check("req_ready_after_hs", bus.req_ready, 1);
    check("busy_after_hs", busy, 0);
    $display("txn %0d a=%0b b=%0b mode=%0d bp=%0d count=%0d xor=%0b expected_count=%0d",
             idx, v.a, v.b, v.mode, v.bp, cnt_seen, xor_seen, expc);
  endtask

  initial begin
    int   lat;
    logic seen_valid;
    vec_t rv;

    bus.req_valid = 1'b0; bus.req_a = 1'b0; bus.req_b = 1'b0; bus.res_ready = 1'b0;
    bus_s.req_valid = 1'b0; bus_s.req_a = 1'b0; bus_s.req_b = 1'b0; bus_s.res_ready = 1'b0;
    core_spike_out = 1'b0;
    s_spike_out = 1'b1;

    vecs[0] = '{a: 1'b1, b: 1'b0, mode: 1, bp: 0,  exp_cnt: 3};
    vecs[1] = '{a: 1'b0, b: 1'b1, mode: 3, bp: 0,  exp_cnt: W + D};
    vecs[2] = '{a: 1'b1, b: 1'b1, mode: 0, bp: 0,  exp_cnt: -1};
    vecs[3] = '{a: 1'b0, b: 1'b0, mode: 0, bp: 10, exp_cnt: -1};
    vecs[4] = '{a: 1'b1, b: 1'b1, mode: 4, bp: 1,  exp_cnt: 0};
    vecs[5] = '{a: 1'b1, b: 1'b0, mode: 5, bp: 0,  exp_cnt: 1};
    vecs[6] = '{a: 1'b0, b: 1'b1, mode: 6, bp: 3,  exp_cnt: 2};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_core_rst_n", core_rst_n, 0);
    check("reset_res_valid", bus.res_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_count", bus.res_spike_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_req_ready", bus.req_ready, 1);
    check("release_core_rst_n", core_rst_n, 1);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    for (int i = 0; i < 6; i++) begin
      rv.a = 1'($urandom_range(0, 1));
      rv.b = 1'($urandom_range(0, 1));
      rv.mode = 0;
      rv.bp = $urandom_range(0, 3);
      rv.exp_cnt = -1;
      run_txn(rv, 7 + i);
    end

    // Saturating instance
    @(negedge clk);
    check("sat_req_ready", bus_s.req_ready, 1);
    bus_s.req_valid = 1'b1; bus_s.req_a = 1'b1; bus_s.req_b = 1'b1;
    @(posedge clk);
    #1;
    bus_s.req_valid = 1'b0;
    lat = 0;
    while (!bus_s.res_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("sat_latency", lat, 21);
    check("sat_count", bus_s.res_spike_count, 15);
    check("sat_xor", bus_s.res_xor, 1);
    bus_s.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_s.res_ready = 1'b0;
    check("sat_res_valid_cleared", bus_s.res_valid, 0);
    $display("txn sat count=%0d latency=%0d", 15, lat);

    // Mid-run reset at RUN cycle 20
    wait_ready("midrun_req_ready");
    bus.req_valid = 1'b1; bus.req_a = 1'b1; bus.req_b = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    core_spike_out = 1'b1;
    repeat (S + 20) @(posedge clk);
    @(negedge clk);
    check("midrun_switch_before", sw0, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_req_ready", bus.req_ready, 0);
    check("midrun_core_rst_n", core_rst_n, 0);
    check("midrun_switch_0", sw0, 0);
    check("midrun_spike_in_0", sp0, 0);
    check("midrun_busy", busy, 0);
    check("midrun_res_valid", bus.res_valid, 0);
    core_spike_out = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_release_ready", bus.req_ready, 1);
    seen_valid = 1'b0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      seen_valid |= bus.res_valid;
    end
    check("midrun_no_result", seen_valid, 0);
    $display("txn midrun_reset discarded");
    run_txn(vecs[0], 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
